// File: rtl/color_stabilizer.sv
// Qualifies raw edge/corner color codes after each cube move and presents a stable pair to determine_state.
// Optional: define COLOR_HOLD_CHECK_EN to re-validate the latched pair against live samples while holding.
module color_stabilizer #(
  parameter int unsigned SETTLE_CYCLES  = 50000,
  parameter int unsigned STABLE_COUNT   = 8,
  parameter int unsigned TIMEOUT_CYCLES = 5000000,
  parameter int unsigned CNT_W          = 23
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       motion_start,
  input  logic       moves_done,
  input  logic       raw_valid,
  input  logic [2:0] edge_raw,
  input  logic [2:0] corner_raw,
  output logic [2:0] edge_color_sensor,
  output logic [2:0] corner_color_sensor,
  output logic       color_sensor_stable,
  output logic       sample_timeout
);

  localparam int unsigned AGREE_W = (STABLE_COUNT < 1) ? 1 : $clog2(STABLE_COUNT + 1);

  localparam logic [CNT_W-1:0]   SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [AGREE_W-1:0] AGREE_TGT    = AGREE_W'(STABLE_COUNT);
  localparam logic [AGREE_W-1:0] AGREE_ONE    = AGREE_W'(1);

  typedef enum logic [1:0] {
    WAIT_MOVE = 2'd0,
    SETTLE    = 2'd1,
    ACQUIRE   = 2'd2,
    HOLD      = 2'd3
  } state_t;

  state_t             state_q,  state_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [AGREE_W-1:0] agree_q,  agree_d;
  logic [5:0]         cand_q,   cand_d;
  logic [2:0]         edge_q,   edge_d;
  logic [2:0]         corner_q, corner_d;
  logic               stable_q, stable_d;
  logic               timeout_q, timeout_d;

  logic               codes_ok;
  logic [5:0]         pair;
  logic [AGREE_W-1:0] agree_inc;
  logic [AGREE_W-1:0] samp_agree;
  logic [5:0]         samp_cand;
  logic               samp_qualifies;

  assign pair      = {edge_raw, corner_raw};
  assign codes_ok  = (edge_raw <= 3'd5) && (corner_raw <= 3'd5);
  assign agree_inc = (agree_q >= AGREE_TGT) ? AGREE_TGT : agree_q + AGREE_ONE;

  // Agreement update for one ACQUIRE sample; invalid codes break the run but keep the candidate.
  always_comb begin
    samp_agree = agree_q;
    samp_cand  = cand_q;
    if (raw_valid) begin
      if (!codes_ok) begin
        samp_agree = '0;
      end else if (pair == cand_q) begin
        samp_agree = agree_inc;
      end else begin
        samp_cand  = pair;
        samp_agree = AGREE_ONE;
      end
    end
  end

  assign samp_qualifies = raw_valid && codes_ok && (samp_agree == AGREE_TGT);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    agree_d   = agree_q;
    cand_d    = cand_q;
    edge_d    = edge_q;
    corner_d  = corner_q;
    stable_d  = stable_q;
    timeout_d = timeout_q;

    if (motion_start) begin
      state_d  = WAIT_MOVE;
      stable_d = 1'b0;
      agree_d  = '0;
    end else if (moves_done) begin
      state_d  = SETTLE;
      cnt_d    = '0;
      stable_d = 1'b0;
      agree_d  = '0;
    end else begin
      case (state_q)
        WAIT_MOVE: ;
        SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            state_d = ACQUIRE;
            cnt_d   = '0;
            agree_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ACQUIRE: begin
          cand_d  = samp_cand;
          agree_d = samp_agree;
          // A qualifying sample wins over a timeout landing in the same cycle.
          if (samp_qualifies) begin
            state_d  = HOLD;
            edge_d   = samp_cand[5:3];
            corner_d = samp_cand[2:0];
            stable_d = 1'b1;
            cnt_d    = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d   = SETTLE;
            timeout_d = 1'b1;
            cnt_d     = '0;
            agree_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        HOLD: begin
`ifdef COLOR_HOLD_CHECK_EN
          if (raw_valid && codes_ok && (pair != {edge_q, corner_q})) begin
            state_d  = ACQUIRE;
            stable_d = 1'b0;
            cand_d   = pair;
            agree_d  = AGREE_ONE;
            cnt_d    = '0;
          end
`endif
        end
        default: state_d = WAIT_MOVE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= WAIT_MOVE;
      cnt_q     <= '0;
      agree_q   <= '0;
      cand_q    <= '0;
      edge_q    <= '0;
      corner_q  <= '0;
      stable_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      agree_q   <= agree_d;
      cand_q    <= cand_d;
      edge_q    <= edge_d;
      corner_q  <= corner_d;
      stable_q  <= stable_d;
      timeout_q <= timeout_d;
    end
  end

  assign edge_color_sensor   = edge_q;
  assign corner_color_sensor = corner_q;
  assign color_sensor_stable = stable_q;
  assign sample_timeout      = timeout_q;

endmodule

// File: tb/tb_color_stabilizer.sv
// Directed scoreboard bench for color_stabilizer (SETTLE=4, STABLE=3, TIMEOUT=20).
// Honors COLOR_HOLD_CHECK_EN for the HOLD re-validation expectations.
module tb_color_stabilizer;

  logic       clock;
  logic       reset_n;
  logic       motion_start;
  logic       moves_done;
  logic       raw_valid;
  logic [2:0] edge_raw;
  logic [2:0] corner_raw;
  logic [2:0] edge_color_sensor;
  logic [2:0] corner_color_sensor;
  logic       color_sensor_stable;
  logic       sample_timeout;

  int unsigned vectors;
  int unsigned miscompares;
  logic [5:0]  exp_q[$];
  logic        exp_prev;
  logic        exp_to;
  logic        dut_prev;

  color_stabilizer #(
    .SETTLE_CYCLES (4),
    .STABLE_COUNT  (3),
    .TIMEOUT_CYCLES(20),
    .CNT_W         (8)
  ) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .motion_start       (motion_start),
    .moves_done         (moves_done),
    .raw_valid          (raw_valid),
    .edge_raw           (edge_raw),
    .corner_raw         (corner_raw),
    .edge_color_sensor  (edge_color_sensor),
    .corner_color_sensor(corner_color_sensor),
    .color_sensor_stable(color_sensor_stable),
    .sample_timeout     (sample_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; a predicted rising stable pushes the qualifying pair.
  task automatic cyc(input logic ms, input logic md, input logic rv,
                     input logic [2:0] e, input logic [2:0] c, input logic exp_st);
    logic [5:0] p;
    motion_start = ms;
    moves_done   = md;
    raw_valid    = rv;
    edge_raw     = e;
    corner_raw   = c;
    if (exp_st && !exp_prev) exp_q.push_back({e, c});
    exp_prev = exp_st;
    @(posedge clock);
    #1;
    motion_start = 1'b0;
    moves_done   = 1'b0;
    raw_valid    = 1'b0;
    chk("stable", 32'(color_sensor_stable), 32'(exp_st));
    chk("timeout", 32'(sample_timeout), 32'(exp_to));
    if (color_sensor_stable === 1'b1 && dut_prev !== 1'b1) begin
      chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        p = exp_q.pop_front();
        chk("sb_pair", 32'({edge_color_sensor, corner_color_sensor}), 32'(p));
      end
    end
    dut_prev = color_sensor_stable;
  endtask

  task automatic idle(input int unsigned n, input logic exp_st);
    for (int unsigned i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, exp_st);
  endtask

  task automatic smp(input logic [2:0] e, input logic [2:0] c, input logic exp_st);
    cyc(1'b0, 1'b0, 1'b1, e, c, exp_st);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_edge"},    32'(edge_color_sensor),   32'd0);
    chk({tag, "_corner"},  32'(corner_color_sensor), 32'd0);
    chk({tag, "_stable"},  32'(color_sensor_stable), 32'd0);
    chk({tag, "_timeout"}, 32'(sample_timeout),      32'd0);
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    exp_prev     = 1'b0;
    exp_to       = 1'b0;
    dut_prev     = 1'b0;
    reset_n      = 1'b0;
    motion_start = 1'b0;
    moves_done   = 1'b0;
    raw_valid    = 1'b0;
    edge_raw     = 3'd0;
    corner_raw   = 3'd0;

    repeat (2) @(posedge clock);
    #1;
    chk_all_zero("reset");
    reset_n = 1'b1;

    // Nominal: samples offered during SETTLE must be ignored
    cyc(1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0);
    for (int unsigned i = 0; i < 4; i++) smp(3'd2, 3'd4, 1'b0);
    smp(3'd2, 3'd4, 1'b0);
    smp(3'd2, 3'd4, 1'b0);
    smp(3'd2, 3'd4, 1'b1);
    idle(2, 1'b1);

    // Disagreement
    cyc(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0);
    idle(4, 1'b0);
    smp(3'd2, 3'd4, 1'b0);
    smp(3'd2, 3'd4, 1'b0);
    smp(3'd3, 3'd4, 1'b0);
    smp(3'd3, 3'd4, 1'b0);
    smp(3'd3, 3'd4, 1'b1);

    // Invalid code breaks the run; moves_done straight out of HOLD
    cyc(1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0);
    idle(4, 1'b0);
    smp(3'd1, 3'd1, 1'b0);
    smp(3'd1, 3'd1, 1'b0);
    smp(3'd7, 3'd1, 1'b0);
    smp(3'd1, 3'd1, 1'b0);
    smp(3'd1, 3'd1, 1'b0);
    smp(3'd1, 3'd1, 1'b1);

    // Timeout after 20 ACQUIRE cycles, then retry through SETTLE
    cyc(1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0);
    idle(4, 1'b0);
    idle(19, 1'b0);
    exp_to = 1'b1;
    idle(1, 1'b0);
    for (int unsigned i = 0; i < 4; i++) smp(3'd4, 3'd3, 1'b0);
    smp(3'd4, 3'd3, 1'b0);
    smp(3'd4, 3'd3, 1'b0);
    smp(3'd4, 3'd3, 1'b1);

    // motion_start beats moves_done: block must sit in WAIT_MOVE
    cyc(1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0);
    for (int unsigned i = 0; i < 8; i++) smp(3'd4, 3'd3, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0);
    idle(4, 1'b0);
    smp(3'd0, 3'd2, 1'b0);
    smp(3'd0, 3'd2, 1'b0);
    smp(3'd0, 3'd2, 1'b1);

    // HOLD latched at (2,4), then a conflicting (5,0) stream
    cyc(1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0);
    idle(4, 1'b0);
    smp(3'd2, 3'd4, 1'b0);
    smp(3'd2, 3'd4, 1'b0);
    smp(3'd2, 3'd4, 1'b1);
    smp(3'd7, 3'd7, 1'b1);
    smp(3'd2, 3'd4, 1'b1);
`ifdef COLOR_HOLD_CHECK_EN
    smp(3'd5, 3'd0, 1'b0);
    smp(3'd5, 3'd0, 1'b0);
    smp(3'd5, 3'd0, 1'b1);
`else
    smp(3'd5, 3'd0, 1'b1);
    smp(3'd5, 3'd0, 1'b1);
    smp(3'd5, 3'd0, 1'b1);
    chk("hold_edge",   32'(edge_color_sensor),   32'd2);
    chk("hold_corner", 32'(corner_color_sensor), 32'd4);
`endif

    // Asynchronous reset in the middle of ACQUIRE
    cyc(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0);
    idle(4, 1'b0);
    smp(3'd2, 3'd4, 1'b0);
    reset_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    exp_to   = 1'b0;
    exp_prev = 1'b0;
    dut_prev = 1'b0;
    #2;
    reset_n = 1'b1;
    for (int unsigned i = 0; i < 8; i++) smp(3'd2, 3'd4, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0);
    idle(4, 1'b0);
    smp(3'd3, 3'd5, 1'b0);
    smp(3'd3, 3'd5, 1'b0);
    smp(3'd3, 3'd5, 1'b1);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/color_stabilizer.md
Name: color_stabilizer

Overview:
- Sits directly upstream of determine_state. Qualifies the raw edge and corner color-sensor codes after each cube move.
- Drives the edge_color_sensor, corner_color_sensor and color_sensor_stable inputs that determine_state observes.
- Waits for motor motion to finish, lets the mechanics settle, then requires N consecutive agreeing valid samples before declaring the colors stable.
- Drops stable as soon as a new move is requested.

Parameters:
- SETTLE_CYCLES, 50000: clock cycles waited after moves_done before sampling starts.
- STABLE_COUNT, 8: consecutive agreeing valid samples required (minimum 1).
- TIMEOUT_CYCLES, 5000000: maximum cycles in ACQUIRE before the block retries.
- CNT_W, 23: width of the settle/timeout counter; must hold max(SETTLE_CYCLES, TIMEOUT_CYCLES).

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- motion_start  in  1  single-cycle pulse, connected to determine_state's send_setup_moves.
- moves_done  in  1  single-cycle pulse from the motor sequencer when all queued moves have completed.
- raw_valid  in  1  sample strobe; edge_raw and corner_raw are valid in this cycle.
- edge_raw  in  3  raw edge-sensor code; 0..5 = W,O,G,Red,Blue,Y; 6 and 7 are invalid.
- corner_raw  in  3  raw corner-sensor code, same encoding.
- edge_color_sensor  out  3  latched qualified edge color.
- corner_color_sensor  out  3  latched qualified corner color.
- color_sensor_stable  out  1  level; high while the latched colors are valid for the current cube position.
- sample_timeout  out  1  sticky error flag; set on any ACQUIRE timeout, cleared only by reset.

Behaviour:
- Reset values: state WAIT_MOVE, all outputs 0, all counters 0, candidate pair 0.
- States: WAIT_MOVE, SETTLE, ACQUIRE, HOLD.
- Priority each cycle: reset_n low > motion_start > moves_done > the current state's own logic.
- motion_start, any state:
  - next state WAIT_MOVE;
  - color_sensor_stable cleared next cycle;
  - agreement counter cleared.
  - If motion_start and moves_done arrive in the same cycle, motion_start wins.
- moves_done, any state (without motion_start): next state SETTLE, counter loaded with 0, stable cleared.
- WAIT_MOVE: idle until moves_done.
- SETTLE:
  - counter increments every cycle;
  - when it reaches SETTLE_CYCLES-1, go to ACQUIRE and clear the counter;
  - i.e. exactly SETTLE_CYCLES cycles are spent in SETTLE;
  - raw_valid is ignored in SETTLE.
- ACQUIRE, per raw_valid cycle:
  - If either code is 6 or 7: agreement counter goes to 0; the candidate is unchanged.
  - Else if the pair {edge_raw, corner_raw} equals the candidate: agreement counter increments.
  - Else: the candidate takes the new pair and the agreement counter goes to 1.
  - When the agreement count reaches STABLE_COUNT (the increment/load result equals STABLE_COUNT): next cycle the outputs take the candidate, color_sensor_stable goes to 1, and the state goes to HOLD.
  - Latency: stable is high on the cycle after the qualifying sample.
- ACQUIRE timeout:
  - the counter increments every cycle;
  - on reaching TIMEOUT_CYCLES-1: set sample_timeout, return to SETTLE (retry), clear the agreement counter.
  - The retry is unbounded.
- HOLD: outputs frozen and stable held high until motion_start or moves_done.
- Counter widths: the agreement counter saturates at STABLE_COUNT and never wraps. The CNT_W counter never exceeds its terminal value.
- Reset mid-operation forces the reset values immediately and asynchronously. The block then waits for a fresh moves_done.

Optional Feature:
- Macro: COLOR_HOLD_CHECK_EN.
- Defined:
  - In HOLD, every valid raw_valid sample is compared against the latched pair.
  - A mismatching valid sample clears stable next cycle, makes that sample the candidate with agreement count 1, clears the timeout counter, and returns to ACQUIRE.
  - Invalid codes in HOLD are ignored.
- Undefined: HOLD ignores raw_valid completely.

Test Plan:
(Parameters: SETTLE_CYCLES=4, STABLE_COUNT=3, TIMEOUT_CYCLES=20.)
- Nominal: moves_done pulse, then raw_valid with edge=2, corner=4 on every cycle from cycle 5 -> stable=1 one cycle after the 3rd agreeing sample; edge_color_sensor=2, corner_color_sensor=4; no sample accepted during the 4 SETTLE cycles.
- Disagreement: samples (2,4),(2,4),(3,4),(3,4),(3,4) -> stable rises after the 5th sample with outputs (3,4).
- Invalid code: samples (1,1),(1,1),(7,1),(1,1),(1,1),(1,1) -> stable only after the 6th sample; outputs (1,1).
- Timeout: no raw_valid for 20 ACQUIRE cycles -> sample_timeout=1 and stays 1; block re-enters SETTLE; later 3 valid agreeing samples give stable=1.
- Motion priority: in HOLD, assert motion_start and moves_done in the same cycle -> stable=0 next cycle, state WAIT_MOVE; a later moves_done restarts SETTLE.
- Reset/HOLD check: reset_n low mid-ACQUIRE -> all outputs 0 immediately.
  - With COLOR_HOLD_CHECK_EN: a (5,0) sample in HOLD latched at (2,4) drops stable, and 2 further (5,0) samples re-assert it with (5,0).
  - Without the macro: the same stimulus leaves stable=1 and outputs (2,4).
